// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, memory req/ack fetch, IF/ID register
// A skid buffer keeps a word that arrives during a pause, so memory is never re-read.
module if_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifi_branch,
  input  logic [15:0] ifi_new_pc,
  input  logic        ifi_pause,
  input  logic        ifi_flush,
  input  logic [15:0] ifi_flush_pc,
  output logic        ifo_mem_req,
  output logic [15:0] ifo_mem_addr,
  input  logic        ifi_mem_ack,
  input  logic [15:0] ifi_mem_data,
  output logic [15:0] ifo_addr,
  output logic [15:0] ifo_instr,
  output logic        ifo_valid
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state;
  logic [15:0] pc;
  logic        hold_valid;
  logic [15:0] hold_addr;
  logic [15:0] hold_instr;
  logic        redir_pending;
  logic [15:0] redir_pc;

  logic        branch_taken;
  logic [15:0] pc_inc;
  logic [15:0] pc_seq;

  assign branch_taken = ifi_branch && ifo_valid;
  assign pc_inc       = pc + 16'd1;
  // A branch seen while the delay-slot fetch was waiting takes effect after that fetch.
  assign pc_seq       = redir_pending ? redir_pc : pc_inc;

  assign ifo_mem_req  = (state == FETCH) && !rst;
  assign ifo_mem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      ifo_addr      <= 16'h0000;
      ifo_instr     <= NOP_INSTR;
      ifo_valid     <= 1'b0;
      hold_valid    <= 1'b0;
      hold_addr     <= 16'h0000;
      hold_instr    <= NOP_INSTR;
      redir_pending <= 1'b0;
      redir_pc      <= 16'h0000;
    end else if (ifi_flush) begin
      state         <= FETCH;
      pc            <= ifi_flush_pc;
      ifo_instr     <= NOP_INSTR;
      ifo_valid     <= 1'b0;
      hold_valid    <= 1'b0;
      redir_pending <= 1'b0;
    end else if (ifi_pause) begin
      if (state == FETCH && ifi_mem_ack) begin
        hold_valid    <= 1'b1;
        hold_addr     <= pc;
        hold_instr    <= ifi_mem_data;
        pc            <= pc_seq;
        redir_pending <= 1'b0;
        state         <= HOLD;
      end
    end else if (state == FETCH) begin
      if (ifi_mem_ack) begin
        ifo_addr      <= pc;
        ifo_instr     <= ifi_mem_data;
        ifo_valid     <= 1'b1;
        pc            <= branch_taken ? ifi_new_pc : pc_seq;
        redir_pending <= 1'b0;
      end else begin
        ifo_instr <= NOP_INSTR;
        ifo_valid <= 1'b0;
        if (branch_taken) begin
          redir_pending <= 1'b1;
          redir_pc      <= ifi_new_pc;
        end
      end
    end else begin
      ifo_addr   <= hold_addr;
      ifo_instr  <= hold_instr;
      ifo_valid  <= hold_valid;
      hold_valid <= 1'b0;
      if (branch_taken) begin
        pc <= ifi_new_pc;
      end
      state <= FETCH;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
// Memory answers combinationally when enabled, returning addr ^ 16'hA5A5.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        ifi_branch;
  logic [15:0] ifi_new_pc;
  logic        ifi_pause;
  logic        ifi_flush;
  logic [15:0] ifi_flush_pc;
  logic        ifo_mem_req;
  logic [15:0] ifo_mem_addr;
  logic        ifi_mem_ack;
  logic [15:0] ifi_mem_data;
  logic [15:0] ifo_addr;
  logic [15:0] ifo_instr;
  logic        ifo_valid;

  logic        ack_en;
  int          checks;
  int          failures;
  int          reads_41;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ifi_branch   (ifi_branch),
    .ifi_new_pc   (ifi_new_pc),
    .ifi_pause    (ifi_pause),
    .ifi_flush    (ifi_flush),
    .ifi_flush_pc (ifi_flush_pc),
    .ifo_mem_req  (ifo_mem_req),
    .ifo_mem_addr (ifo_mem_addr),
    .ifi_mem_ack  (ifi_mem_ack),
    .ifi_mem_data (ifi_mem_data),
    .ifo_addr     (ifo_addr),
    .ifo_instr    (ifo_instr),
    .ifo_valid    (ifo_valid)
  );

  assign ifi_mem_ack  = ack_en && ifo_mem_req;
  assign ifi_mem_data = ifi_mem_ack ? (ifo_mem_addr ^ 16'hA5A5) : 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && ifo_mem_req && ifi_mem_ack && ifo_mem_addr == 16'h0041)
      reads_41 <= reads_41 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (ifo_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ifo_valid); end
    checks++; if (ifo_instr !== 16'h0800) begin failures++; $display("FAIL reset_instr got=%h exp=0800", ifo_instr); end
    checks++; if (ifo_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", ifo_addr); end
    checks++; if (ifo_mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", ifo_mem_req); end
  endtask

  task automatic test_sequential();
    logic [15:0] a;
    rst = 1'b0;
    #1;
    checks++; if (ifo_mem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", ifo_mem_req); end
    checks++; if (ifo_mem_addr !== 16'h0000) begin failures++; $display("FAIL first_addr got=%h exp=0000", ifo_mem_addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      a = 16'(i);
      checks++; if (ifo_addr !== a) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, ifo_addr, a); end
      checks++; if (ifo_instr !== (a ^ 16'hA5A5)) begin failures++; $display("FAIL seq_instr%0d got=%h exp=%h", i, ifo_instr, a ^ 16'hA5A5); end
      checks++; if (ifo_valid !== 1'b1) begin failures++; $display("FAIL seq_valid%0d got=%b exp=1", i, ifo_valid); end
    end
  endtask

  task automatic test_branch();
    tick();
    checks++; if (ifo_addr !== 16'h0004) begin failures++; $display("FAIL br_addr4 got=%h exp=0004", ifo_addr); end
    checks++; if (ifo_mem_addr !== 16'h0005) begin failures++; $display("FAIL br_memaddr5 got=%h exp=0005", ifo_mem_addr); end
    ifi_branch = 1'b1;
    ifi_new_pc = 16'h0040;
    tick();
    ifi_branch = 1'b0;
    checks++; if (ifo_addr !== 16'h0005 || ifo_valid !== 1'b1) begin failures++; $display("FAIL br_slot got=%h/%b exp=0005/1", ifo_addr, ifo_valid); end
    checks++; if (ifo_mem_addr !== 16'h0040) begin failures++; $display("FAIL br_target_fetch got=%h exp=0040", ifo_mem_addr); end
    tick();
    checks++; if (ifo_addr !== 16'h0040) begin failures++; $display("FAIL br_addr40 got=%h exp=0040", ifo_addr); end
    tick();
    checks++; if (ifo_addr !== 16'h0041) begin failures++; $display("FAIL br_addr41 got=%h exp=0041", ifo_addr); end
  endtask

  task automatic test_branch_wait();
    ifi_flush    = 1'b1;
    ifi_flush_pc = 16'h0004;
    tick();
    ifi_flush = 1'b0;
    tick();
    checks++; if (ifo_addr !== 16'h0004 || ifo_valid !== 1'b1) begin failures++; $display("FAIL bw_addr4 got=%h/%b exp=0004/1", ifo_addr, ifo_valid); end
    ack_en     = 1'b0;
    ifi_branch = 1'b1;
    ifi_new_pc = 16'h0040;
    for (int i = 0; i < 2; i++) begin
      tick();
      ifi_branch = 1'b0;
      checks++; if (ifo_valid !== 1'b0 || ifo_instr !== 16'h0800) begin failures++; $display("FAIL bw_bubble%0d got=%b/%h exp=0/0800", i, ifo_valid, ifo_instr); end
      checks++; if (ifo_mem_req !== 1'b1 || ifo_mem_addr !== 16'h0005) begin failures++; $display("FAIL bw_wait_addr%0d got=%b/%h exp=1/0005", i, ifo_mem_req, ifo_mem_addr); end
    end
    ack_en = 1'b1;
    tick();
    checks++; if (ifo_addr !== 16'h0005 || ifo_valid !== 1'b1) begin failures++; $display("FAIL bw_slot got=%h/%b exp=0005/1", ifo_addr, ifo_valid); end
    checks++; if (ifo_mem_addr !== 16'h0040) begin failures++; $display("FAIL bw_target_fetch got=%h exp=0040", ifo_mem_addr); end
    tick();
    checks++; if (ifo_addr !== 16'h0040 || ifo_valid !== 1'b1) begin failures++; $display("FAIL bw_addr40 got=%h/%b exp=0040/1", ifo_addr, ifo_valid); end
  endtask

  task automatic test_pause();
    int base;
    base      = reads_41;
    ifi_pause = 1'b1;
    ack_en    = 1'b0;
    tick();
    checks++; if (ifo_addr !== 16'h0040 || ifo_valid !== 1'b1) begin failures++; $display("FAIL pause_frozen0 got=%h/%b exp=0040/1", ifo_addr, ifo_valid); end
    checks++; if (ifo_mem_req !== 1'b1) begin failures++; $display("FAIL pause_req0 got=%b exp=1", ifo_mem_req); end
    ack_en = 1'b1;
    tick();
    checks++; if (ifo_addr !== 16'h0040 || ifo_valid !== 1'b1) begin failures++; $display("FAIL pause_frozen1 got=%h/%b exp=0040/1", ifo_addr, ifo_valid); end
    checks++; if (ifo_mem_req !== 1'b0) begin failures++; $display("FAIL pause_req_drop got=%b exp=0", ifo_mem_req); end
    tick();
    checks++; if (ifo_addr !== 16'h0040 || ifo_mem_req !== 1'b0) begin failures++; $display("FAIL pause_frozen2 got=%h/%b exp=0040/0", ifo_addr, ifo_mem_req); end
    ifi_pause = 1'b0;
    tick();
    checks++; if (ifo_addr !== 16'h0041 || ifo_instr !== (16'h0041 ^ 16'hA5A5) || ifo_valid !== 1'b1) begin failures++; $display("FAIL pause_release got=%h/%h/%b exp=0041/%h/1", ifo_addr, ifo_instr, ifo_valid, 16'h0041 ^ 16'hA5A5); end
    checks++; if (ifo_mem_req !== 1'b1 || ifo_mem_addr !== 16'h0042) begin failures++; $display("FAIL pause_next_fetch got=%b/%h exp=1/0042", ifo_mem_req, ifo_mem_addr); end
    tick();
    checks++; if (ifo_addr !== 16'h0042) begin failures++; $display("FAIL pause_after got=%h exp=0042", ifo_addr); end
    checks++; if (reads_41 - base !== 1) begin failures++; $display("FAIL pause_single_read got=%0d exp=1", reads_41 - base); end
  endtask

  task automatic test_flush();
    ifi_pause    = 1'b1;
    ifi_flush    = 1'b1;
    ifi_flush_pc = 16'h0008;
    ack_en       = 1'b1;
    tick();
    ifi_flush = 1'b0;
    ifi_pause = 1'b0;
    checks++; if (ifo_valid !== 1'b0 || ifo_instr !== 16'h0800) begin failures++; $display("FAIL flush_bubble got=%b/%h exp=0/0800", ifo_valid, ifo_instr); end
    checks++; if (ifo_mem_req !== 1'b1 || ifo_mem_addr !== 16'h0008) begin failures++; $display("FAIL flush_req got=%b/%h exp=1/0008", ifo_mem_req, ifo_mem_addr); end
    tick();
    checks++; if (ifo_addr !== 16'h0008 || ifo_valid !== 1'b1) begin failures++; $display("FAIL flush_first got=%h/%b exp=0008/1", ifo_addr, ifo_valid); end
    checks++; if (ifo_mem_addr !== 16'h0009) begin failures++; $display("FAIL flush_next got=%h exp=0009", ifo_mem_addr); end
  endtask

  task automatic test_wrap();
    ifi_flush    = 1'b1;
    ifi_flush_pc = 16'hFFFF;
    tick();
    ifi_flush = 1'b0;
    checks++; if (ifo_mem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_pc got=%h exp=ffff", ifo_mem_addr); end
    tick();
    checks++; if (ifo_addr !== 16'hFFFF || ifo_valid !== 1'b1) begin failures++; $display("FAIL wrap_last got=%h/%b exp=ffff/1", ifo_addr, ifo_valid); end
    checks++; if (ifo_mem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_next got=%h exp=0000", ifo_mem_addr); end
    tick();
    checks++; if (ifo_addr !== 16'h0000 || ifo_instr !== 16'hA5A5) begin failures++; $display("FAIL wrap_zero got=%h/%h exp=0000/a5a5", ifo_addr, ifo_instr); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reads_41     = 0;
    rst          = 1'b1;
    ifi_branch   = 1'b0;
    ifi_new_pc   = 16'h0000;
    ifi_pause    = 1'b0;
    ifi_flush    = 1'b0;
    ifi_flush_pc = 16'h0000;
    ack_en       = 1'b1;
    test_reset();
    test_sequential();
    test_branch();
    test_branch_wait();
    test_pause();
    test_flush();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
